// File: rtl/pipe_ctrl_unit.sv
// ID-stage control unit: decodes the instruction into a registered control word,
// detects load-use and mult/div hazards, and tracks mult/div unit occupancy.
module pipe_ctrl_unit #(
    parameter int ALUOP_W = 6,
    parameter int MD_LAT  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic [4:0]         rs,
    input  logic [4:0]         rt,
    input  logic               id_valid,
    input  logic               ex_memread,
    input  logic [4:0]         ex_rt,
    input  logic               flush,
    output logic               Jump,
    output logic               Branch,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrc,
    output logic [ALUOP_W-1:0] AluOp,
    output logic               ctrl_valid,
    output logic               stall,
    output logic               md_busy
);

    localparam int CNT_W = $clog2(MD_LAT);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_MD_RUN = 1'b1;

    logic load, store, itype, btype, rtype, jtype;
    logic md_op, hilo_rd, lu_haz, md_haz, issue;
    logic [7:0]         ctrl_next;
    logic [4:0]         alu_low;
    logic [ALUOP_W-1:0] alu_next;

    logic [7:0]         ctrl_reg;
    logic [ALUOP_W-1:0] alu_reg;
    logic               valid_reg;
    logic [0:0]         state_reg;
    logic [CNT_W-1:0]   cnt_reg;

    assign load    = (opcode[5:3] == 3'b100);
    assign store   = (opcode[5:3] == 3'b101);
    assign itype   = (opcode[5:3] == 3'b001);
    assign btype   = (opcode[5:1] == 5'b00010);
    assign rtype   = (opcode == 6'b000000);
    assign jtype   = (opcode == 6'b000010);
    assign md_op   = rtype && (funct == 6'b011000 || funct == 6'b011010);
    assign hilo_rd = rtype && (funct == 6'b010000 || funct == 6'b010010);

    // Order: Jump, Branch, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrc
    assign ctrl_next = {jtype, btype, load, store, load,
                        rtype && !md_op,
                        load || itype || (rtype && !md_op),
                        load || store || itype};

    assign alu_low = {opcode[2:0], rtype || itype, btype || itype};

    generate
        for (genvar gi = 0; gi < ALUOP_W; gi++) begin : g_aluop
            if (gi < 5) begin : g_low
                assign alu_next[gi] = alu_low[gi];
            end else begin : g_high
                assign alu_next[gi] = 1'b0;
            end
        end
    endgenerate

    // rt only counts as a source for formats that actually read it
    assign lu_haz = ex_memread && (ex_rt != 5'd0) &&
                    ((ex_rt == rs) || ((ex_rt == rt) && (rtype || store || btype)));
    assign md_haz = (state_reg == ST_MD_RUN) && (md_op || hilo_rd);
    assign stall  = id_valid && !flush && (lu_haz || md_haz);
    assign issue  = id_valid && !flush && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_reg  <= '0;
            alu_reg   <= '0;
            valid_reg <= 1'b0;
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            if (issue) begin
                ctrl_reg  <= ctrl_next;
                alu_reg   <= alu_next;
                valid_reg <= 1'b1;
            end else begin
                ctrl_reg  <= '0;
                alu_reg   <= '0;
                valid_reg <= 1'b0;
            end

            // Counter runs MD_LAT-1 down to 0, so MD_RUN lasts exactly MD_LAT cycles
            case (state_reg)
                ST_IDLE: begin
                    if (issue && md_op) begin
                        state_reg <= ST_MD_RUN;
                        cnt_reg   <= CNT_W'(MD_LAT - 1);
                    end
                end
                ST_MD_RUN: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign {Jump, Branch, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrc} = ctrl_reg;
    assign AluOp      = alu_reg;
    assign ctrl_valid = valid_reg;
    assign md_busy    = (state_reg == ST_MD_RUN);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: an instruction-class model predicts every cycle,
// and literal expectations pin the key scenarios.
module tb_pipe_ctrl_unit;

    localparam int ALUOP_W = 6;
    localparam int MD_LAT  = 4;

    localparam int C_OTHER = 0, C_R = 1, C_J = 2, C_BR = 3, C_I = 4, C_LOAD = 5, C_STORE = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, id_valid, ex_memread, flush;
    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, ex_rt;
    logic Jump, Branch, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrc;
    logic [ALUOP_W-1:0] AluOp;
    logic ctrl_valid, stall, md_busy;
    logic [7:0] dut_ctrl;

    assign dut_ctrl = {Jump, Branch, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrc};

    pipe_ctrl_unit #(.ALUOP_W(ALUOP_W), .MD_LAT(MD_LAT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt),
        .id_valid(id_valid), .ex_memread(ex_memread), .ex_rt(ex_rt), .flush(flush),
        .Jump(Jump), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
        .AluOp(AluOp), .ctrl_valid(ctrl_valid), .stall(stall), .md_busy(md_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_no   = 0;

    // Model state: remaining busy cycles and the expected registered word
    int         md_left   = 0;
    logic [7:0] exp_ctrl  = '0;
    logic [5:0] exp_alu   = '0;
    logic       exp_valid = 1'b0;
    logic       model_ok  = 1'b0;

    function automatic int cls_of(input logic [5:0] op);
        if (op == 6'd0)                 return C_R;
        if (op == 6'b000010)            return C_J;
        if (op == 6'b000100 || op == 6'b000101) return C_BR;
        if (op[5:3] == 3'b001)          return C_I;
        if (op[5:3] == 3'b100)          return C_LOAD;
        if (op[5:3] == 3'b101)          return C_STORE;
        return C_OTHER;
    endfunction

    function automatic bit is_md(input logic [5:0] op, input logic [5:0] fn);
        return cls_of(op) == C_R && (fn == 6'd24 || fn == 6'd26);
    endfunction

    function automatic bit is_hilo(input logic [5:0] op, input logic [5:0] fn);
        return cls_of(op) == C_R && (fn == 6'd16 || fn == 6'd18);
    endfunction

    function automatic logic [7:0] word_flags(input logic [5:0] op, input logic [5:0] fn);
        case (cls_of(op))
            C_LOAD:  return 8'b0010_1011;
            C_STORE: return 8'b0001_0001;
            C_I:     return 8'b0000_0011;
            C_BR:    return 8'b0100_0000;
            C_J:     return 8'b1000_0000;
            C_R:     return is_md(op, fn) ? 8'b0000_0000 : 8'b0000_0110;
            default: return 8'b0000_0000;
        endcase
    endfunction

    function automatic logic [5:0] word_alu(input logic [5:0] op);
        logic [1:0] lo;
        case (cls_of(op))
            C_BR:    lo = 2'b01;
            C_I:     lo = 2'b11;
            C_R:     lo = 2'b10;
            default: lo = 2'b00;
        endcase
        return {1'b0, op[2:0], lo};
    endfunction

    function automatic bit model_stall();
        int  c;
        bit  uses_rt, lu, md;
        c       = cls_of(opcode);
        uses_rt = (c == C_R) || (c == C_STORE) || (c == C_BR);
        lu      = ex_memread && ex_rt != 0 && (ex_rt == rs || (uses_rt && ex_rt == rt));
        md      = (md_left > 0) && (is_md(opcode, funct) || is_hilo(opcode, funct));
        return id_valid && !flush && (lu || md);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    task automatic compare();
        check("cmp_stall", 32'(stall), 32'(model_stall()));
        check("cmp_ctrl", 32'(dut_ctrl), 32'(exp_ctrl));
        check("cmp_aluop", 32'(AluOp), 32'(exp_alu));
        check("cmp_valid", 32'(ctrl_valid), 32'(exp_valid));
        check("cmp_busy", 32'(md_busy), 32'(md_left > 0));
    endtask

    task automatic model_edge();
        bit st;
        st = model_stall();
        if (reset) begin
            md_left = 0; exp_ctrl = '0; exp_alu = '0; exp_valid = 1'b0;
        end else begin
            bit was_busy;
            was_busy = md_left > 0;
            if (md_left > 0) md_left--;
            if (id_valid && !flush && !st) begin
                exp_ctrl  = word_flags(opcode, funct);
                exp_alu   = word_alu(opcode);
                exp_valid = 1'b1;
                if (is_md(opcode, funct) && !was_busy) md_left = MD_LAT;
            end else begin
                exp_ctrl = '0; exp_alu = '0; exp_valid = 1'b0;
            end
        end
    endtask

    // One clock: compare mid-cycle, update model on the edge, resume just after it
    task automatic cyc();
        @(negedge clk);
        if (model_ok) compare();
        $display("cyc %0d rst=%0b v=%0b op=%b fn=%b rs=%0d rt=%0d exr=%0b exrt=%0d fl=%0b | stall=%0b ctrl=%b alu=%b cv=%0b busy=%0b",
                 cyc_no, reset, id_valid, opcode, funct, rs, rt, ex_memread, ex_rt, flush,
                 stall, dut_ctrl, AluOp, ctrl_valid, md_busy);
        @(posedge clk);
        model_edge();
        if (reset) model_ok = 1'b1;
        cyc_no++;
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] s, input logic [4:0] t);
        id_valid = 1'b1; opcode = op; funct = fn; rs = s; rt = t;
        #1;
    endtask

    task automatic idle();
        id_valid = 1'b0; opcode = '0; funct = '0; rs = '0; rt = '0;
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ex_memread = 1'b0; ex_rt = '0;
        idle();

        // Load-use stalls even while reset is held
        ex_memread = 1'b1; ex_rt = 5'd5;
        instr(6'b000000, 6'b100000, 5'd5, 5'd6);
        check("pin_stall_in_reset", 32'(stall), 32'd1);
        cyc();
        ex_memread = 1'b0; idle();
        cyc();
        check("pin_reset_ctrl", 32'(dut_ctrl), 32'd0);
        check("pin_reset_valid", 32'(ctrl_valid), 32'd0);
        check("pin_reset_busy", 32'(md_busy), 32'd0);
        reset = 1'b0;

        // lw, no hazard
        instr(6'b100011, 6'd0, 5'd1, 5'd2);
        cyc();
        check("pin_lw_ctrl", 32'(dut_ctrl), 32'b0010_1011);
        check("pin_lw_aluop", 32'(AluOp), 32'b001100);
        check("pin_lw_valid", 32'(ctrl_valid), 32'd1);

        // Load-use on rs, then release
        ex_memread = 1'b1; ex_rt = 5'd5;
        instr(6'b000000, 6'b100000, 5'd5, 5'd6);
        check("pin_lu_stall", 32'(stall), 32'd1);
        cyc();
        check("pin_lu_bubble", 32'(ctrl_valid), 32'd0);
        ex_memread = 1'b0; #1;
        check("pin_lu_release", 32'(stall), 32'd0);
        cyc();
        check("pin_add_regdst", 32'(RegDst), 32'd1);
        check("pin_add_aluop", 32'(AluOp), 32'b000010);
        check("pin_add_valid", 32'(ctrl_valid), 32'd1);

        // Hazard boundaries: rt only matters for R/store/branch; ex_rt==0 never hazards
        ex_memread = 1'b1; ex_rt = 5'd9;
        instr(6'b001000, 6'd0, 5'd1, 5'd9);
        check("pin_addi_rt_nohaz", 32'(stall), 32'd0);
        cyc();
        instr(6'b101011, 6'd0, 5'd1, 5'd9);
        check("pin_sw_rt_haz", 32'(stall), 32'd1);
        cyc();
        ex_rt = 5'd0;
        instr(6'b000000, 6'b100000, 5'd0, 5'd0);
        check("pin_r0_nohaz", 32'(stall), 32'd0);
        cyc();
        ex_memread = 1'b0;
        idle();
        cyc();
        check("pin_idle_bubble", 32'(ctrl_valid), 32'd0);

        // mult occupancy with mflo/addi interleaved
        instr(6'b000000, 6'b011000, 5'd1, 5'd2);
        cyc();
        check("pin_mult_busy0", 32'(md_busy), 32'd1);
        instr(6'b000000, 6'b010010, 5'd0, 5'd0);
        check("pin_mflo_stall1", 32'(stall), 32'd1);
        cyc();
        instr(6'b001000, 6'd0, 5'd3, 5'd4);
        check("pin_addi_nostall", 32'(stall), 32'd0);
        check("pin_mult_busy2", 32'(md_busy), 32'd1);
        cyc();
        check("pin_addi_valid", 32'(ctrl_valid), 32'd1);
        instr(6'b000000, 6'b010010, 5'd0, 5'd0);
        check("pin_mflo_stall3", 32'(stall), 32'd1);
        cyc();
        check("pin_mult_busy4", 32'(md_busy), 32'd1);
        check("pin_mflo_stall4", 32'(stall), 32'd1);
        cyc();
        check("pin_mult_done", 32'(md_busy), 32'd0);
        check("pin_mflo_go", 32'(stall), 32'd0);
        cyc();
        check("pin_mflo_valid", 32'(ctrl_valid), 32'd1);

        // Flush beats a load-use hazard
        ex_memread = 1'b1; ex_rt = 5'd7; flush = 1'b1;
        instr(6'b100011, 6'd0, 5'd7, 5'd8);
        check("pin_flush_nostall", 32'(stall), 32'd0);
        cyc();
        check("pin_flush_bubble", 32'(ctrl_valid), 32'd0);
        ex_memread = 1'b0; flush = 1'b0;

        // Flush does not abort MD_RUN
        instr(6'b000000, 6'b011010, 5'd1, 5'd2);
        cyc();
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr(6'b000000, 6'b100000, 5'd1, 5'd2);
            check("pin_flush_md_busy", 32'(md_busy), 32'd1);
            cyc();
        end
        flush = 1'b0;
        idle();
        check("pin_flush_md_last", 32'(md_busy), 32'd1);
        cyc();
        check("pin_flush_md_end", 32'(md_busy), 32'd0);

        // Reset in the second MD_RUN cycle
        instr(6'b000000, 6'b011000, 5'd1, 5'd2);
        cyc();
        idle();
        cyc();
        reset = 1'b1;
        check("pin_pre_reset_busy", 32'(md_busy), 32'd1);
        cyc();
        check("pin_mdreset_busy", 32'(md_busy), 32'd0);
        check("pin_mdreset_ctrl", 32'(dut_ctrl), 32'd0);
        check("pin_mdreset_alu", 32'(AluOp), 32'd0);
        reset = 1'b0;
        instr(6'b000000, 6'b011000, 5'd1, 5'd2);
        check("pin_remult_nostall", 32'(stall), 32'd0);
        cyc();
        check("pin_remult_busy", 32'(md_busy), 32'd1);
        check("pin_remult_valid", 32'(ctrl_valid), 32'd1);
        idle();
        for (int i = 0; i < MD_LAT; i++) cyc();

        // beq and j
        instr(6'b000100, 6'd0, 5'd1, 5'd2);
        cyc();
        check("pin_beq_branch", 32'(Branch), 32'd1);
        check("pin_beq_aluop", 32'(AluOp), 32'b010001);
        check("pin_beq_regwrite", 32'(RegWrite), 32'd0);
        instr(6'b000010, 6'd0, 5'd0, 5'd0);
        cyc();
        check("pin_j_ctrl", 32'(dut_ctrl), 32'b1000_0000);
        idle();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
